// File: rtl/dz_msr_pkg.sv
// Shared constants and helpers for the DZ modem status register block.
// Bit map of the status/change words: CO lines above RI lines.
package dz_msr_pkg;

    localparam int DZ_MAX_LINES = 16;
    localparam int RI_BASE      = 0;

    // Counter must hold 0..DEB_CNT-1; sized for DEB_CNT+1 codes so DEB_CNT=1 still gets a bit.
    function automatic int cnt_width(input int deb_cnt);
        return (deb_cnt < 1) ? 1 : $clog2(deb_cnt + 1);
    endfunction

    function automatic int co_base(input int nlines);
        return nlines;
    endfunction

endpackage

// File: rtl/dz_sync_debounce.sv
// One-bit synchroniser followed by a consecutive-stable-cycle debounce filter.
// Emits the accepted level and a strobe in the cycle whose closing edge moves it.
module dz_sync_debounce
    import dz_msr_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CNT     = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic pulse
);

    localparam int             CW   = cnt_width(DEB_CNT);
    localparam logic [CW-1:0]  TERM = CW'(DEB_CNT - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   lvl_q, lvl_d;
    logic                   s;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        s      = sync_q[SYNC_STAGES-1];
        lvl_d  = lvl_q;
        cnt_d  = '0;
        pulse  = 1'b0;
        if (s != lvl_q) begin
            if (cnt_q == TERM) begin
                lvl_d = s;
                pulse = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            cnt_q  <= '0;
            lvl_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            lvl_q  <= lvl_d;
        end
    end

    assign dout = lvl_q;

endmodule

// File: rtl/dz_msr_chg.sv
// DZ modem status register: debounced CO/RI levels, sticky W1C change flags
// and a registered level interrupt request.
module dz_msr_chg
    import dz_msr_pkg::*;
#(
    parameter int NLINES      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CNT     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NLINES-1:0]   dzCO,
    input  logic [NLINES-1:0]   dzRI,
    input  logic                chgIE,
    input  logic                clrWR,
    input  logic [2*NLINES-1:0] clrDAT,
    output logic [2*NLINES-1:0] regMSR,
    output logic [2*NLINES-1:0] regCHG,
    output logic                chgIRQ
);

    localparam int NBITS   = 2 * NLINES;
    localparam int CO_BASE = co_base(NLINES);

    logic [NBITS-1:0] raw, lvl, pulse;
    logic [NBITS-1:0] chg_q, chg_d, clr_mask;
    logic             irq_q, irq_d;

    assign raw[CO_BASE +: NLINES] = dzCO;
    assign raw[RI_BASE +: NLINES] = dzRI;

    for (genvar i = 0; i < NBITS; i++) begin : g_bit
        dz_sync_debounce #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEB_CNT     (DEB_CNT)
        ) u_deb (
            .clk   (clk),
            .rst   (rst),
            .din   (raw[i]),
            .dout  (lvl[i]),
            .pulse (pulse[i])
        );
    end

    // Set is OR-ed in after the clear so a change landing on a clear write survives.
    always_comb begin
        clr_mask = clrWR ? clrDAT : '0;
        chg_d    = (chg_q & ~clr_mask) | pulse;
        irq_d    = chgIE & (|chg_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chg_q <= '0;
            irq_q <= 1'b0;
        end else begin
            chg_q <= chg_d;
            irq_q <= irq_d;
        end
    end

    assign regMSR = lvl;
    assign regCHG = chg_q;
    assign chgIRQ = irq_q;

endmodule

// File: tb/tb_dz_msr_chg.sv
// Self-checking bench: default build plus NLINES=16/SYNC_STAGES=3/DEB_CNT=1 build,
// both compared each cycle against a sliding-window reference model.
module tb_dz_msr_chg;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0]  a_co, a_ri;
    logic        a_ie, a_wr, a_irq;
    logic [15:0] a_dat, a_msr, a_chg;

    logic [15:0] b_co, b_ri;
    logic        b_ie, b_wr, b_irq;
    logic [31:0] b_dat, b_msr, b_chg;

    dz_msr_chg #(.NLINES(8), .SYNC_STAGES(2), .DEB_CNT(8)) u_dut_a (
        .clk(clk), .rst(rst), .dzCO(a_co), .dzRI(a_ri), .chgIE(a_ie), .clrWR(a_wr),
        .clrDAT(a_dat), .regMSR(a_msr), .regCHG(a_chg), .chgIRQ(a_irq)
    );

    dz_msr_chg #(.NLINES(16), .SYNC_STAGES(3), .DEB_CNT(1)) u_dut_b (
        .clk(clk), .rst(rst), .dzCO(b_co), .dzRI(b_ri), .chgIE(b_ie), .clrWR(b_wr),
        .clrDAT(b_dat), .regMSR(b_msr), .regCHG(b_chg), .chgIRQ(b_irq)
    );

    int cmp_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        cmp_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: a level is accepted once the last DEB_CNT synchronised
    // samples all disagree with it; samples reach the filter SYNC_STAGES edges late.
    logic [31:0] hist [2][16];
    logic [31:0] m_d   [2];
    logic [31:0] m_chg [2];
    logic        m_irq [2];

    task automatic model_edge(input int u, input logic [31:0] raw, input logic r,
                              input logic ie, input logic wr, input logic [31:0] dat);
        int          sy, db, nb;
        logic [31:0] set;
        sy = (u == 0) ? 2 : 3;
        db = (u == 0) ? 8 : 1;
        nb = (u == 0) ? 16 : 32;
        if (r) begin
            for (int j = 0; j < 16; j++) hist[u][j] = '0;
            m_d[u]   = '0;
            m_chg[u] = '0;
            m_irq[u] = 1'b0;
        end else begin
            for (int j = 15; j > 0; j--) hist[u][j] = hist[u][j-1];
            hist[u][0] = raw;
            set = '0;
            for (int b = 0; b < nb; b++) begin
                logic all_diff;
                all_diff = 1'b1;
                for (int j = sy; j < sy + db; j++)
                    if (hist[u][j][b] == m_d[u][b]) all_diff = 1'b0;
                set[b] = all_diff;
            end
            m_irq[u] = ie & (|m_chg[u]);
            m_d[u]   = m_d[u] ^ set;
            m_chg[u] = (m_chg[u] & ~(wr ? dat : 32'h0)) | set;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(0, {16'h0, a_co, a_ri}, rst, a_ie, a_wr, {16'h0, a_dat});
        model_edge(1, {b_co, b_ri}, rst, b_ie, b_wr, b_dat);
        #1;
        check("a_msr", {16'h0, a_msr}, m_d[0]);
        check("a_chg", {16'h0, a_chg}, m_chg[0]);
        check("a_irq", {31'h0, a_irq}, {31'h0, m_irq[0]});
        check("b_msr", b_msr, m_d[1]);
        check("b_chg", b_chg, m_chg[1]);
        check("b_irq", {31'h0, b_irq}, {31'h0, m_irq[1]});
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    function automatic logic [31:0] sparse(input int k);
        logic [31:0] v;
        v = $urandom;
        for (int i = 1; i < k; i++) v = v & $urandom;
        return v;
    endfunction

    initial begin
        logic [31:0] v;
        a_co = '0; a_ri = '0; a_ie = 1'b0; a_wr = 1'b0; a_dat = '0;
        b_co = '0; b_ri = '0; b_ie = 1'b0; b_wr = 1'b0; b_dat = '0;
        rst  = 1'b1;

        // Reset with carrier present on every line
        a_co = 8'hFF;
        repeat (3) begin
            tick();
            check("rst_msr", {16'h0, a_msr}, 32'h0);
            check("rst_chg", {16'h0, a_chg}, 32'h0);
            check("rst_irq", {31'h0, a_irq}, 32'h0);
        end
        rst = 1'b0;
        ticks(9);
        check("post_rst_9", {16'h0, a_msr}, 32'h0);
        tick();
        check("post_rst_msr", {16'h0, a_msr}, 32'h0000_FF00);
        check("post_rst_chg", {16'h0, a_chg}, 32'h0000_FF00);

        // Drop carriers, clear flags, then a clean rising edge on CO[3]
        a_co = 8'h00;
        ticks(12);
        a_wr = 1'b1; a_dat = 16'hFFFF;
        tick();
        a_wr = 1'b0;
        check("clr_all", {16'h0, a_chg}, 32'h0);
        a_ie = 1'b1;
        tick();
        a_co[3] = 1'b1;
        ticks(9);
        check("edge_pre", {31'h0, a_msr[11]}, 32'h0);
        tick();
        check("edge_msr", {31'h0, a_msr[11]}, 32'h1);
        check("edge_chg", {31'h0, a_chg[11]}, 32'h1);
        check("edge_irq0", {31'h0, a_irq}, 32'h0);
        tick();
        check("edge_irq1", {31'h0, a_irq}, 32'h1);
        a_wr = 1'b1; a_dat = 16'h0800;
        tick();
        a_wr = 1'b0;
        tick();
        check("edge_irq_off", {31'h0, a_irq}, 32'h0);

        // Glitch of DEB_CNT-1 cycles is rejected, DEB_CNT cycles is accepted
        a_ri[5] = 1'b1;
        ticks(7);
        a_ri[5] = 1'b0;
        ticks(12);
        check("glitch_msr", {16'h0, a_msr}, 32'h0000_0800);
        check("glitch_chg", {16'h0, a_chg}, 32'h0);
        check("glitch_irq", {31'h0, a_irq}, 32'h0);
        a_ri[5] = 1'b1;
        ticks(8);
        a_ri[5] = 1'b0;
        ticks(2);
        check("pulse8_msr", {31'h0, a_msr[5]}, 32'h1);
        check("pulse8_chg", {16'h0, a_chg}, 32'h0000_0020);
        ticks(8);
        check("pulse8_fall", {31'h0, a_msr[5]}, 32'h0);

        // Write-one-to-clear, one bit at a time
        a_wr = 1'b1; a_dat = 16'hFFFF;
        tick();
        a_wr = 1'b0;
        a_co[3] = 1'b0; a_ri[4] = 1'b1;
        ticks(10);
        check("w1c_setup", {16'h0, a_chg}, 32'h0000_0810);
        a_wr = 1'b1; a_dat = 16'h0800;
        tick();
        check("w1c_one", {16'h0, a_chg}, 32'h0000_0010);
        check("w1c_irq_on", {31'h0, a_irq}, 32'h1);
        a_dat = 16'h0010;
        tick();
        a_wr = 1'b0;
        check("w1c_two", {16'h0, a_chg}, 32'h0);
        check("w1c_irq_lag", {31'h0, a_irq}, 32'h1);
        tick();
        check("w1c_irq_off", {31'h0, a_irq}, 32'h0);

        // Clear write landing on the edge that sets RI[0]: set wins
        a_ri[0] = 1'b1;
        ticks(9);
        a_wr = 1'b1; a_dat = 16'h0001;
        tick();
        check("coll_chg", {31'h0, a_chg[0]}, 32'h1);
        check("coll_msr", {31'h0, a_msr[0]}, 32'h1);
        tick();
        a_wr = 1'b0;
        check("coll_after", {31'h0, a_chg[0]}, 32'h0);

        // Interrupt enable gating
        a_ri[0] = 1'b0;
        ticks(11);
        check("ie_irq", {31'h0, a_irq}, 32'h1);
        a_ie = 1'b0;
        tick();
        check("ie_off_irq", {31'h0, a_irq}, 32'h0);
        check("ie_off_chg", {31'h0, a_chg[0]}, 32'h1);
        a_ie = 1'b1;
        tick();
        check("ie_on_irq", {31'h0, a_irq}, 32'h1);

        // Minimal-debounce build: 4-cycle latency, 1-cycle glitch gives two changes
        b_co[15] = 1'b1;
        ticks(3);
        check("b_edge_pre", {31'h0, b_msr[31]}, 32'h0);
        tick();
        check("b_edge_msr", {31'h0, b_msr[31]}, 32'h1);
        check("b_edge_chg", {31'h0, b_chg[31]}, 32'h1);
        b_wr = 1'b1; b_dat = 32'hFFFF_FFFF;
        tick();
        b_wr = 1'b0;
        b_co[15] = 1'b0;
        tick();
        b_co[15] = 1'b1;
        ticks(3);
        check("b_glitch_low", {31'h0, b_msr[31]}, 32'h0);
        check("b_glitch_chg", {31'h0, b_chg[31]}, 32'h1);
        tick();
        check("b_glitch_high", {31'h0, b_msr[31]}, 32'h1);

        // Randomised traffic, including occasional mid-debounce resets
        for (int n = 0; n < 800; n++) begin
            v = sparse(3);  a_co ^= v[7:0];  a_ri ^= v[15:8];
            v = sparse(2);  b_co ^= v[15:0]; b_ri ^= v[31:16];
            if ($urandom_range(7) == 0) a_ie = ~a_ie;
            if ($urandom_range(7) == 0) b_ie = ~b_ie;
            a_wr  = ($urandom_range(3) == 0);
            a_dat = 16'($urandom);
            b_wr  = ($urandom_range(3) == 0);
            b_dat = $urandom;
            rst   = ($urandom_range(199) == 0);
            tick();
        end
        rst = 1'b0;
        ticks(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/dz_msr_chg.md
Name: dz_msr_chg

Overview:
- Parametrised next-generation DZ modem status register.
- Synchronises and debounces per-line Carrier Detect (CO) and Ring Indicator (RI) inputs for NLINES lines.
- Latches sticky change flags and raises a modem-status-change interrupt request.
- Sits between the line-interface pins and the DZ register file/interrupt logic; regMSR keeps the legacy {CO,RI} bit layout.

Parameters:
- NLINES, 8, number of serial lines (1..16).
- SYNC_STAGES, 2, synchroniser flops per input bit (>=2).
- DEB_CNT, 8, consecutive stable cycles required before a new level is accepted (>=1; 1 = no debounce).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- dzCO  in  NLINES  raw carrier detect, asynchronous to clk.
- dzRI  in  NLINES  raw ring indicator, asynchronous to clk.
- chgIE  in  1  change-interrupt enable.
- clrWR  in  1  one-cycle write strobe to the change register.
- clrDAT  in  2*NLINES  write-one-to-clear data for regCHG (same bit map as regMSR).
- regMSR  out  2*NLINES  debounced status, [2N-1:N]=CO, [N-1:0]=RI.
- regCHG  out  2*NLINES  sticky change flags, same map.
- chgIRQ  out  1  registered interrupt request.

Behaviour:
- Single clock domain. Reset is synchronous, active-high. All state clears on rst: sync chains, debounce counters, regMSR, regCHG, chgIRQ all = 0.
- Synchroniser:
  - Each of the 2*NLINES input bits passes through SYNC_STAGES flops.
  - Concatenation order is {dzCO, dzRI}.
- Debounce, per bit:
  - State: stable level D (drives regMSR) and counter C, width $clog2(DEB_CNT+1).
  - If synced S == D: C <= 0.
  - If S != D and C == DEB_CNT-1: D <= S, C <= 0, one-cycle change pulse P.
  - If S != D otherwise: C <= C+1.
  - Any return of S to D before terminal count restarts the count, so glitches shorter than DEB_CNT cycles are rejected entirely.
  - DEB_CNT=1: D follows S one cycle later, and every transition pulses P.
  - Latency from a raw edge (held stable) to regMSR update: SYNC_STAGES + DEB_CNT clock edges. P occurs in the same cycle D updates.
- Change register, per bit:
  - Set on P (both rising and falling transitions, CO and RI alike).
  - Cleared when clrWR=1 and clrDAT bit = 1.
  - Set and clear in the same cycle: set wins, so flag = 1.
  - clrWR with clrDAT bit = 0 leaves the flag unchanged.
- Interrupt:
  - chgIRQ <= chgIE & |regCHG. It is a level, registered, and one cycle after regCHG.
  - Dropping chgIE deasserts chgIRQ next cycle without touching regCHG.
  - Re-enabling with flags pending reasserts it.
- Reset mid-debounce: the counter discards progress. After rst deasserts, inputs re-qualify from D=0, so any line held high produces a fresh change after SYNC_STAGES+DEB_CNT cycles. This is intentional: software sees carrier-present as a change after init.
- No wrap-around is possible: the counter saturates via the terminal-count reset.

Decomposition:
- Package dz_msr_pkg:
  - Line-count limit constant DZ_MAX_LINES=16.
  - Function for the counter width.
  - Localparam helpers for CO/RI bit offsets: CO_BASE=NLINES, RI_BASE=0.
- One natural sub-module: dz_sync_debounce, a one-bit synchroniser plus debounce counter emitting D and P.
  - Parameters SYNC_STAGES and DEB_CNT.
  - Instantiated 2*NLINES times by a generate loop.
- Top level holds regCHG, the clear logic and chgIRQ.

Test Plan:
- Reset: drive dzCO=8'hFF, assert rst 3 cycles -> regMSR, regCHG, chgIRQ all 0 during rst. After release, regMSR=16'hFF00 exactly 10 cycles later (defaults), regCHG=16'hFF00.
- Clean edge: chgIE=1, raise dzCO[3] and hold -> regMSR[11]=1 and regCHG[11]=1 on cycle 10, chgIRQ=1 on cycle 11.
- Glitch: pulse dzRI[5] high for 7 cycles (DEB_CNT-1) -> regMSR and regCHG never change, chgIRQ stays 0. Repeat with 8 cycles -> bit 5 set.
- W1C: regCHG=16'h0810, clrWR=1, clrDAT=16'h0800 -> regCHG=16'h0010 next cycle, chgIRQ still 1. Then clear 16'h0010 -> regCHG=0, chgIRQ=0 one cycle after.
- Set/clear collision: time clrWR with clrDAT[0]=1 to the cycle P fires on RI[0] -> regCHG[0]=1.
- Parameter sweep: NLINES=16, SYNC_STAGES=3, DEB_CNT=1 -> dzCO[15] edge appears at regMSR[31] after 4 cycles. A 1-cycle glitch is accepted as two changes, with regCHG[31] set.
